// File: rtl/sample_packetizer.sv
// Multi-channel snapshot packetizer: requests one acquisition snapshot per trigger and
// streams it to the UART as SYNC, sequence, left-justified channel payload, XOR checksum.
module sample_packetizer #(
    parameter int          N_BIT     = 8,
    parameter int          N_CH      = 1,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trig_start,
    output logic                   req_data,
    input  logic                   data_valid,
    input  logic [N_CH*N_BIT-1:0]  data_aq,
    input  logic                   uart_ready,
    output logic [7:0]             data_out,
    output logic                   data_ready,
    output logic                   busy,
    output logic                   overrun
);

    localparam int B  = (N_BIT + 7) / 8;
    localparam int SW = B * 8;
    localparam int PW = N_CH * SW;

    typedef enum logic [2:0] {IDLE, WAIT, HDR, SEQ, DATA, CSUM} state_t;

    state_t          state_q, state_d;
    logic [7:0]      seq_q, seq_d;
    logic [7:0]      csum_q, csum_d;
    logic [2:0]      byteCnt_q, byteCnt_d;
    logic [4:0]      chCnt_q, chCnt_d;
    logic [PW-1:0]   snap_q, snap_d;
    logic            reqData_q, reqData_d;
    logic            overrun_q, overrun_d;

    logic [PW-1:0]   fmtAq;
    logic [PW-1:0]   payShift;
    logic [7:0]      payByte;

    // Snapshot is stored pre-formatted: channel 0 in the top bits, each sample left-justified.
    always_comb begin
        fmtAq = '0;
        for (int c = 0; c < N_CH; c++) begin
            fmtAq[(N_CH-1-c)*SW +: SW] = SW'(data_aq[c*N_BIT +: N_BIT]) << (SW - N_BIT);
        end
    end

    always_comb begin
        payShift = snap_q << (8 * (int'(chCnt_q) * B + int'(byteCnt_q)));
        payByte  = payShift[PW-1 -: 8];
    end

    assign busy     = (state_q != IDLE);
    assign req_data = reqData_q;
    assign overrun  = overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            seq_q     <= '0;
            csum_q    <= '0;
            byteCnt_q <= '0;
            chCnt_q   <= '0;
            snap_q    <= '0;
            reqData_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            csum_q    <= csum_d;
            byteCnt_q <= byteCnt_d;
            chCnt_q   <= chCnt_d;
            snap_q    <= snap_d;
            reqData_q <= reqData_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        csum_d     = csum_q;
        byteCnt_d  = byteCnt_q;
        chCnt_d    = chCnt_q;
        snap_d     = snap_q;
        reqData_d  = 1'b0;
        overrun_d  = trig_start && busy;
        data_out   = '0;
        data_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig_start) begin
                    state_d   = WAIT;
                    reqData_d = 1'b1;
                    csum_d    = '0;
                    byteCnt_d = '0;
                    chCnt_d   = '0;
                end
            end
            WAIT: begin
                if (data_valid) begin
                    snap_d  = fmtAq;
                    state_d = HDR;
                end
            end
            HDR: begin
                data_out   = SYNC_BYTE;
                data_ready = 1'b1;
                if (uart_ready) state_d = SEQ;
            end
            SEQ: begin
                data_out   = seq_q;
                data_ready = 1'b1;
                if (uart_ready) state_d = DATA;
            end
            DATA: begin
                data_out   = payByte;
                data_ready = 1'b1;
                if (uart_ready) begin
                    if (byteCnt_q == 3'(B - 1)) begin
                        byteCnt_d = '0;
                        if (chCnt_q == 5'(N_CH - 1)) begin
                            chCnt_d = '0;
                            state_d = CSUM;
                        end else begin
                            chCnt_d = chCnt_q + 5'd1;
                        end
                    end else begin
                        byteCnt_d = byteCnt_q + 3'd1;
                    end
                end
            end
            CSUM: begin
                data_out   = csum_q;
                data_ready = 1'b1;
                if (uart_ready) begin
                    seq_d   = seq_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Checksum ends up as the XOR of every byte already sent, header included.
        if (data_ready && uart_ready) csum_d = csum_q ^ data_out;
    end

endmodule

// File: tb/tb_sample_packetizer.sv
// Directed bench for sample_packetizer: three instances cover 12-bit x2, 8-bit x1 and 1-bit x3
// configurations; inputs are driven and outputs sampled on the falling clock edge.
module tb_sample_packetizer;

    logic        clk = 1'b0;
    logic        reset;

    logic        trigA, dvA, urA, reqA, rdyA, busyA, ovA;
    logic [23:0] aqA;
    logic [7:0]  outA;

    logic        trigB, dvB, urB, reqB, rdyB, busyB, ovB;
    logic [7:0]  aqB;
    logic [7:0]  outB;

    logic        trigC, dvC, urC, reqC, rdyC, busyC, ovC;
    logic [2:0]  aqC;
    logic [7:0]  outC;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sample_packetizer #(.N_BIT(12), .N_CH(2)) dutA (
        .clk(clk), .reset(reset), .trig_start(trigA), .req_data(reqA), .data_valid(dvA),
        .data_aq(aqA), .uart_ready(urA), .data_out(outA), .data_ready(rdyA), .busy(busyA),
        .overrun(ovA));

    sample_packetizer dutB (
        .clk(clk), .reset(reset), .trig_start(trigB), .req_data(reqB), .data_valid(dvB),
        .data_aq(aqB), .uart_ready(urB), .data_out(outB), .data_ready(rdyB), .busy(busyB),
        .overrun(ovB));

    sample_packetizer #(.N_BIT(1), .N_CH(3)) dutC (
        .clk(clk), .reset(reset), .trig_start(trigC), .req_data(reqC), .data_valid(dvC),
        .data_aq(aqC), .uart_ready(urC), .data_out(outC), .data_ready(rdyC), .busy(busyC),
        .overrun(ovC));

    task automatic tick;
        @(negedge clk);
    endtask

    // Trigger dutA and deliver the snapshot two cycles after req_data; returns with HDR presented.
    task automatic startA(input logic [23:0] aq);
        trigA = 1'b1;
        tick;
        trigA = 1'b0;
        tick;
        tick;
        dvA = 1'b1;
        aqA = aq;
        tick;
        dvA = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        trigA = 0; dvA = 0; urA = 1; aqA = '0;
        trigB = 0; dvB = 0; urB = 1; aqB = '0;
        trigC = 0; dvC = 0; urC = 1; aqC = '0;
        tick;
        tick;
        vectors++;
        if ({reqA, outA, rdyA, busyA, ovA} !== 12'h0) begin
            miscompares++;
            $display("[TB] FAIL reset A: got %h, want 000", {reqA, outA, rdyA, busyA, ovA});
        end
        vectors++;
        if ({reqB, outB, rdyB, busyB, ovB} !== 12'h0) begin
            miscompares++;
            $display("[TB] FAIL reset B: got %h, want 000", {reqB, outB, rdyB, busyB, ovB});
        end
        vectors++;
        if ({reqC, outC, rdyC, busyC, ovC} !== 12'h0) begin
            miscompares++;
            $display("[TB] FAIL reset C: got %h, want 000", {reqC, outC, rdyC, busyC, ovC});
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        logic [7:0] exp [7];
        exp = '{8'hA5, 8'h00, 8'hAB, 8'hC0, 8'h12, 8'h30, 8'hEC};
        trigA = 1'b1;
        tick;
        trigA = 1'b0;
        vectors++;
        if (reqA !== 1'b1 || busyA !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic req: got req=%b busy=%b, want 1 1", reqA, busyA);
        end
        tick;
        vectors++;
        if (reqA !== 1'b0 || busyA !== 1'b1 || rdyA !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic wait: got req=%b busy=%b rdy=%b, want 0 1 0", reqA, busyA, rdyA);
        end
        tick;
        dvA = 1'b1;
        aqA = 24'h123ABC;
        tick;
        dvA = 1'b0;
        aqA = '0;
        for (int i = 0; i < 7; i++) begin
            vectors++;
            if (rdyA !== 1'b1 || outA !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL basic byte %0d: got rdy=%b data=%h, want rdy=1 data=%h", i, rdyA, outA, exp[i]);
            end
            tick;
        end
        vectors++;
        if (busyA !== 1'b0 || rdyA !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic end: got busy=%b rdy=%b, want 0 0", busyA, rdyA);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp [7];
        int   got = 0;
        int   cyc = 0;
        logic ur;
        logic prevStall = 1'b0;
        logic [7:0] prevByte = '0;
        exp = '{8'hA5, 8'h01, 8'hAB, 8'hC0, 8'h12, 8'h30, 8'hED};
        startA(24'h123ABC);
        while (got < 7 && cyc < 64) begin
            ur  = (cyc % 4 == 0) || (cyc % 4 == 3);
            urA = ur;
            dvA = (cyc == 2);
            if (cyc == 2) aqA = 24'hFFFFFF;
            if (rdyA === 1'b1) begin
                if (prevStall) begin
                    vectors++;
                    if (outA !== prevByte) begin
                        miscompares++;
                        $display("[TB] FAIL bp hold cyc %0d: got %h, want %h", cyc, outA, prevByte);
                    end
                end
                if (ur) begin
                    vectors++;
                    if (outA !== exp[got]) begin
                        miscompares++;
                        $display("[TB] FAIL bp byte %0d: got %h, want %h", got, outA, exp[got]);
                    end
                    got++;
                end
                prevStall = !ur;
                prevByte  = outA;
            end else begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL bp ready cyc %0d: got rdy=%b, want 1", cyc, rdyA);
                prevStall = 1'b0;
            end
            cyc++;
            tick;
        end
        urA = 1'b1;
        dvA = 1'b0;
        vectors++;
        if (got != 7) begin
            miscompares++;
            $display("[TB] FAIL bp timeout: got %0d bytes, want 7", got);
        end
        vectors++;
        if (busyA !== 1'b0 || rdyA !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp end: got busy=%b rdy=%b, want 0 0", busyA, rdyA);
        end
    endtask

    task automatic test_overrun;
        logic [7:0] exp [7];
        exp = '{8'hA5, 8'h02, 8'hAB, 8'hC0, 8'h12, 8'h30, 8'hEE};
        startA(24'h123ABC);
        for (int i = 0; i < 7; i++) begin
            vectors++;
            if (rdyA !== 1'b1 || outA !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL ovr byte %0d: got rdy=%b data=%h, want rdy=1 data=%h", i, rdyA, outA, exp[i]);
            end
            vectors++;
            if (ovA !== (i == 4)) begin
                miscompares++;
                $display("[TB] FAIL ovr pulse %0d: got %b, want %b", i, ovA, (i == 4));
            end
            trigA = (i == 3) || (i == 6);
            tick;
        end
        trigA = 1'b0;
        vectors++;
        if (ovA !== 1'b1 || busyA !== 1'b0 || rdyA !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ovr csum: got ov=%b busy=%b rdy=%b, want 1 0 0", ovA, busyA, rdyA);
        end
        tick;
        vectors++;
        if (ovA !== 1'b0 || busyA !== 1'b0 || reqA !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ovr idle: got ov=%b busy=%b req=%b, want 0 0 0", ovA, busyA, reqA);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] exp [7];
        exp = '{8'hA5, 8'h00, 8'hAB, 8'hC0, 8'h12, 8'h30, 8'hEC};
        startA(24'h123ABC);
        for (int i = 0; i < 3; i++) tick;
        vectors++;
        if (rdyA !== 1'b1 || outA !== 8'hC0) begin
            miscompares++;
            $display("[TB] FAIL rst pre: got rdy=%b data=%h, want rdy=1 data=c0", rdyA, outA);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        vectors++;
        if ({reqA, outA, rdyA, busyA, ovA} !== 12'h0) begin
            miscompares++;
            $display("[TB] FAIL rst outputs: got %h, want 000", {reqA, outA, rdyA, busyA, ovA});
        end
        tick;
        startA(24'h123ABC);
        for (int i = 0; i < 7; i++) begin
            vectors++;
            if (rdyA !== 1'b1 || outA !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL rst byte %0d: got rdy=%b data=%h, want rdy=1 data=%h", i, rdyA, outA, exp[i]);
            end
            tick;
        end
    endtask

    task automatic test_seq_wrap;
        logic [7:0] exp [4];
        for (int f = 0; f < 257; f++) begin
            exp = '{8'hA5, 8'(f), 8'h5A, 8'hA5 ^ 8'(f) ^ 8'h5A};
            trigB = 1'b1;
            tick;
            trigB = 1'b0;
            tick;
            dvB = 1'b1;
            aqB = 8'h5A;
            tick;
            dvB = 1'b0;
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (rdyB !== 1'b1 || outB !== exp[i]) begin
                    miscompares++;
                    $display("[TB] FAIL wrap frame %0d byte %0d: got rdy=%b data=%h, want rdy=1 data=%h", f, i, rdyB, outB, exp[i]);
                end
                tick;
            end
        end
        vectors++;
        if (busyB !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wrap end: got busy=%b, want 0", busyB);
        end
    endtask

    task automatic test_one_bit;
        logic [7:0] exp [6];
        exp = '{8'hA5, 8'h00, 8'h80, 8'h00, 8'h80, 8'hA5};
        trigC = 1'b1;
        tick;
        trigC = 1'b0;
        tick;
        dvC = 1'b1;
        aqC = 3'b101;
        tick;
        dvC = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (rdyC !== 1'b1 || outC !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL onebit byte %0d: got rdy=%b data=%h, want rdy=1 data=%h", i, rdyC, outC, exp[i]);
            end
            tick;
        end
        vectors++;
        if (busyC !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL onebit end: got busy=%b, want 0", busyC);
        end
    endtask

    initial begin
        tick;
        test_reset;
        test_basic;
        test_backpressure;
        test_overrun;
        test_reset_mid_frame;
        test_seq_wrap;
        test_one_bit;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
